// File: rtl/rr_stream_mux.sv
// rr_stream_mux: CH-way round-robin stream mux feeding one registered valid/ready output stage.
// Define RR_STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module rr_stream_mux #(
  parameter int CH = 8,
  parameter int W  = 3,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        in_valid,
  input  logic [CH-1:0][W-1:0] in_data,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  input  logic [CH-1:0]        in_last,
  output logic                 out_last,
`endif
  output logic [CH-1:0]        in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic [SEL_W-1:0] ptr, grant, next_ptr;
  logic [CH-1:0]    req;
  logic             any_req, load_en, xfer;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;

  // While a packet is open only the owning channel is allowed to request.
  always_comb begin
    req = in_valid;
    if (locked) begin
      req          = '0;
      req[lock_ch] = in_valid[lock_ch];
    end
  end
`else
  assign req = in_valid;
`endif

  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    grant   = '0;
    for (int k = 0; k < CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CH) idx = idx - CH;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = SEL_W'(idx);
      end
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign xfer     = load_en && any_req && !rst;
  assign next_ptr = (grant == SEL_W'(CH-1)) ? '0 : grant + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load_en) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant];
        out_sel   <= grant;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        out_last  <= in_last[grant];
        locked    <= !in_last[grant];
        lock_ch   <= grant;
        if (in_last[grant]) ptr <= next_ptr;
`else
        ptr       <= next_ptr;
`endif
      end else begin
        // Drained with nothing to load: data/sel keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the fixed 8:1 3-bit mux: CH input channels of W-bit data, each with a valid/ready handshake.
- Round-robin arbitration selects the channel; the selection is held in a registered output stage with valid/ready backpressure.
- Sits between multiple producer datapaths and a single shared consumer. Provides fair, lossless channel selection without an external sel.

Parameters:
- CH, 8, number of input channels; legal range 2..64.
- W, 3, data width per channel in bits; minimum 1.
- SEL_W, $clog2(CH), localparam; width of the channel index. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  CH  per-channel data-valid.
- in_data  input  [CH-1:0][W-1:0]  per-channel data; channel i is in_data[i].
- in_ready  output  CH  per-channel accept; combinational; at most one bit high per cycle.
- out_valid  output  1  registered output valid.
- out_data  output  W  registered output data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - Lock state (optional feature) cleared.
  - A beat held in the output register is dropped; in_ready=0 while rst is high.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en is high.
- Arbitration (combinational):
  - grant = first i in order ptr, ptr+1, ..., CH-1, 0, ..., ptr-1 with in_valid[i]=1.
  - Search wraps modulo CH. Non-power-of-2 CH is legal; indices >= CH are never granted.
- in_ready[i] = load_en && any(in_valid) && (i == grant). An input transfer occurs when in_valid[i] && in_ready[i].
- On a transfer at a clock edge:
  - out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
  - ptr <= (grant == CH-1) ? 0 : grant+1.
- If load_en=1 and no in_valid is high: out_valid <= 0, ptr unchanged, out_data/out_sel hold their last values.
- If load_en=0: all registers hold. in_valid may change freely; nothing is accepted.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready=1. A simultaneous output drain and input load in the same cycle is required, with no bubble.
- out_data/out_sel are stable while out_valid=1 && out_ready=0.
- Fairness: with all CH channels continuously valid and out_ready=1, grants cycle 0,1,...,CH-1,0,...
- A channel that drops valid before being granted is skipped; no stale grant.
- in_data of non-granted channels is ignored. X on non-granted in_data must not propagate to out_data.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds input port in_last [CH-1:0] and output port out_last (1 bit, registered, reset 0).
  - After a transfer with in_last[grant]=0, arbitration locks to that channel. Only that channel may receive in_ready until a beat with in_last=1 transfers.
  - ptr advances only on the last beat. While locked, the other channels' valid is ignored.
  - out_last <= in_last[grant] on each transfer.
- When not defined: the ports do not exist, every beat is arbitrated independently, and there is no lock state.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. The first post-reset transfer is from channel 0.
- Fairness: CH=8, W=3, in_data[i]=i, all in_valid=1, out_ready=1 for 10 cycles -> out_sel/out_data sequence 0,1,...,7,0,1. One transfer per cycle, no bubbles.
- Wrap/skip: only channels 2 and 6 valid, ptr=7 -> grants 2,6,2,6. Channels 0,1,3,4,5,7 never see in_ready.
- Backpressure: out_valid=1 holding data 5 on sel 5, out_ready=0 for 4 cycles -> out_data=5 and out_sel=5 stable, in_ready=0. On out_ready=1, the next grant loads in the same cycle.
- Non-power-of-2: CH=5, all valid -> sel sequence 0,1,2,3,4,0. A glitch-free wrap from 4 to 0 is required.
- Reset mid-flight (with RR_STREAM_MUX_PKT_LOCK_EN): channel 3 sends a 3-beat packet; assert rst after beat 2 -> out_valid=0 asynchronously and the lock is released. After rst deassert, channel 0 is granted first despite channel 3 still being valid.
